dlx_multicycle_ctrl: RTL and testbench

- Main control finite-state machine (FSM) for the multicycle DLX core.
- Sequences instruction fetch, decode, execute, memory access and writeback over a shared datapath with one ALU and one memory port.
- Generates all datapath enables and mux selects, including the `alu_op` code consumed by the ALU decoder.
- Stretches memory states with a ready handshake and bounds waits with a timeout counter.

---
 rtl/dlx_ctrl_pkg.sv | 64 ++++++
 rtl/dlx_opclass_decode.sv | 27 ++
 rtl/dlx_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_dlx_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_ctrl_pkg.sv
// Shared types and encodings for the multicycle DLX control FSM.
package dlx_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_WB_ALU   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_HALT     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SUBI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_SLLI = 6'h14;
  localparam logic [5:0] OP_SRLI = 6'h16;
  localparam logic [5:0] OP_SRAI = 6'h17;
  localparam logic [5:0] OP_SEQI = 6'h18;
  localparam logic [5:0] OP_SNEI = 6'h19;
  localparam logic [5:0] OP_SLTI = 6'h1a;
  localparam logic [5:0] OP_SLEI = 6'h1c;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_HALT = 6'h3f;

  localparam logic [3:0] CLS_R       = 4'd0;
  localparam logic [3:0] CLS_IALU    = 4'd1;
  localparam logic [3:0] CLS_LW      = 4'd2;
  localparam logic [3:0] CLS_SW      = 4'd3;
  localparam logic [3:0] CLS_BEQZ    = 4'd4;
  localparam logic [3:0] CLS_BNEZ    = 4'd5;
  localparam logic [3:0] CLS_J       = 4'd6;
  localparam logic [3:0] CLS_HALT    = 4'd7;
  localparam logic [3:0] CLS_ILLEGAL = 4'd8;

  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_BEQZ  = 3'd1;
  localparam logic [2:0] ALU_OP_LW    = 3'd2;
  localparam logic [2:0] ALU_OP_SW    = 3'd3;
  localparam logic [2:0] ALU_OP_FUNCT = 3'd4;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_FOUR = 2'd1;
  localparam logic [1:0] ALUB_IMM  = 2'd2;

endpackage

// File: rtl/dlx_opclass_decode.sv
// Combinational opcode -> instruction class decoder.
module dlx_opclass_decode
  import dlx_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [3:0] op_class_o
);

  // Classify the opcode; anything unlisted is illegal.
  always_comb begin
    op_class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_R:    op_class_o = CLS_R;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
      OP_SRLI, OP_SRAI, OP_SEQI, OP_SNEI, OP_SLTI, OP_SLEI:
               op_class_o = CLS_IALU;
      OP_LW:   op_class_o = CLS_LW;
      OP_SW:   op_class_o = CLS_SW;
      OP_BEQZ: op_class_o = CLS_BEQZ;
      OP_BNEZ: op_class_o = CLS_BNEZ;
      OP_J:    op_class_o = CLS_J;
      OP_HALT: op_class_o = CLS_HALT;
      default: op_class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/dlx_multicycle_ctrl.sv
// Main control FSM of the multicycle DLX core.
// Optional macro CTRL_TRAP_EN: illegal opcodes and memory timeouts enter an absorbing TRAP state.
module dlx_multicycle_ctrl
  import dlx_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       halted,
  output logic       trap
);

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [5:0] opcode_q, opcode_d;
  logic [3:0] op_class_s;
  logic       waiting_s;
`ifdef CTRL_TRAP_EN
  logic       timeout_s;
`endif

  dlx_opclass_decode u_opclass (
    .opcode_i   (opcode),
    .op_class_o (op_class_s)
  );

  assign waiting_s = ((state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                      (state_q == ST_MEM_WR)) && !mem_ready;
`ifdef CTRL_TRAP_EN
  // This wait cycle is the WAIT_MAX-th one without a ready.
  assign timeout_s = waiting_s && (({1'b0, wait_cnt_q} + 9'd1) >= {1'b0, WAIT_MAX_C});
`endif

  // State, wait counter and latched opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= 8'd0;
      opcode_q   <= OP_R;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
    end
  end

  // Opcode is captured while DECODE dispatches on it.
  always_comb begin
    if (state_q == ST_DECODE) begin
      opcode_d = opcode;
    end else begin
      opcode_d = opcode_q;
    end
  end

  // Wait counter: cleared on any state change, saturating while a memory state waits.
  always_comb begin
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (waiting_s && (wait_cnt_q < WAIT_MAX_C)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Next-state and output decode; outputs are forced low while reset is asserted.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_INC;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REG;
    alu_op     = ALU_OP_ADD;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    trap       = 1'b0;
    if (!rst_n) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ALUB_FOUR;
          alu_op    = ALU_OP_ADD;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_DECODE;
          end
`ifdef CTRL_TRAP_EN
          else if (timeout_s) begin
            state_d = ST_TRAP;
          end
`endif
          else begin
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          alu_src_b = ALUB_IMM;
          alu_op    = ALU_OP_ADD;
          case (op_class_s)
            CLS_R:              state_d = ST_EXEC_R;
            CLS_IALU:           state_d = ST_EXEC_I;
            CLS_LW, CLS_SW:     state_d = ST_MEM_ADDR;
            CLS_BEQZ, CLS_BNEZ: state_d = ST_BRANCH;
            CLS_J:              state_d = ST_JUMP;
            CLS_HALT:           state_d = ST_HALT;
            default: begin
`ifdef CTRL_TRAP_EN
              state_d = ST_TRAP;
`else
              retire  = 1'b1;
              state_d = ST_FETCH;
`endif
            end
          endcase
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_REG;
          alu_op    = ALU_OP_FUNCT;
          state_d   = ST_WB_ALU;
        end
        ST_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_op    = ALU_OP_FUNCT;
          state_d   = ST_WB_ALU;
        end
        ST_WB_ALU: begin
          reg_we  = 1'b1;
          reg_dst = (opcode_q == OP_R);
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          if (opcode_q == OP_SW) begin
            alu_op  = ALU_OP_SW;
            state_d = ST_MEM_WR;
          end else begin
            alu_op  = ALU_OP_LW;
            state_d = ST_MEM_RD;
          end
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            state_d = ST_WB_MEM;
          end
`ifdef CTRL_TRAP_EN
          else if (timeout_s) begin
            state_d = ST_TRAP;
          end
`endif
          else begin
            state_d = ST_MEM_RD;
          end
        end
        ST_WB_MEM: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          reg_dst    = 1'b0;
          retire     = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
`ifdef CTRL_TRAP_EN
          else if (timeout_s) begin
            state_d = ST_TRAP;
          end
`endif
          else begin
            state_d = ST_MEM_WR;
          end
        end
        ST_BRANCH: begin
          alu_op  = ALU_OP_BEQZ;
          pc_src  = PC_SRC_BRANCH;
          retire  = 1'b1;
          pc_we   = (opcode_q == OP_BNEZ) ? !zero : zero;
          state_d = ST_FETCH;
        end
        ST_JUMP: begin
          pc_src  = PC_SRC_JUMP;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
        ST_HALT: begin
          halted  = 1'b1;
          state_d = ST_HALT;
        end
`ifdef CTRL_TRAP_EN
        ST_TRAP: begin
          trap    = 1'b1;
          state_d = ST_TRAP;
        end
`endif
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_multicycle_ctrl.sv
// Randomized self-checking bench: an instruction-level model expands each instruction
// into its expected per-cycle control vector, compared against the DUT every cycle.
module tb_dlx_multicycle_ctrl;

  localparam int WMAX = 4;
`ifdef CTRL_TRAP_EN
  localparam int MAXW = WMAX - 1;
`else
  localparam int MAXW = 7;
`endif

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQZ = 4, K_BNEZ = 5,
                 K_J = 6, K_HALT = 7, K_ILL = 8;

  // Control-vector fields, MSB first: mem_req .. trap.
  localparam logic [18:0] M_TRAP  = 19'd1 << 0;
  localparam logic [18:0] M_HALT  = 19'd1 << 1;
  localparam logic [18:0] M_RET   = 19'd1 << 2;
  localparam logic [18:0] M_M2R   = 19'd1 << 3;
  localparam logic [18:0] M_RDST  = 19'd1 << 4;
  localparam logic [18:0] M_RWE   = 19'd1 << 5;
  localparam logic [18:0] M_ALUA  = 19'd1 << 11;
  localparam logic [18:0] M_PCWE  = 19'd1 << 14;
  localparam logic [18:0] M_IRWE  = 19'd1 << 15;
  localparam logic [18:0] M_IORD  = 19'd1 << 16;
  localparam logic [18:0] M_MWE   = 19'd1 << 17;
  localparam logic [18:0] M_MREQ  = 19'd1 << 18;
  localparam logic [18:0] B_FOUR  = 19'd1 << 9;
  localparam logic [18:0] B_IMM   = 19'd2 << 9;
  localparam logic [18:0] A_BEQZ  = 19'd1 << 6;
  localparam logic [18:0] A_LW    = 19'd2 << 6;
  localparam logic [18:0] A_SW    = 19'd3 << 6;
  localparam logic [18:0] A_FUNCT = 19'd4 << 6;
  localparam logic [18:0] P_BR    = 19'd1 << 12;
  localparam logic [18:0] P_JMP   = 19'd2 << 12;
  localparam logic [18:0] V_FETCH = M_MREQ | B_FOUR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic       reg_we, reg_dst, mem_to_reg, retire, halted, trap;
  logic [18:0] out_vec;

  typedef struct packed {
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [18:0] ev;
  } step_t;

  step_t sq[$];
  string tq[$];
  int    n_checks = 0;
  int    n_errors = 0;

  dlx_multicycle_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire),
    .halted(halted), .trap(trap)
  );

  assign out_vec = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                    alu_op, reg_we, reg_dst, mem_to_reg, retire, halted, trap};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op);
    if (op == 6'h00) return K_R;
    if (op inside {6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h14, 6'h16, 6'h17,
                   6'h18, 6'h19, 6'h1a, 6'h1c}) return K_I;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2b) return K_SW;
    if (op == 6'h04) return K_BEQZ;
    if (op == 6'h05) return K_BNEZ;
    if (op == 6'h02) return K_J;
    if (op == 6'h3f) return K_HALT;
    return K_ILL;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  task automatic push(input logic mr, input logic z, input logic [5:0] op,
                      input logic [18:0] ev, input string tag);
    step_t s;
    s.mr = mr; s.z = z; s.op = op; s.ev = ev;
    sq.push_back(s);
    tq.push_back(tag);
  endtask

  // Expand one instruction into expected cycles (fw fetch waits, mw data waits).
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input logic zv);
    int  k;
    logic taken;
    k = kind_of(op);
    for (int i = 0; i < fw; i++) push(1'b0, rb(), ro(), V_FETCH, "fetch_wait");
    push(1'b1, rb(), ro(), V_FETCH | M_IRWE | M_PCWE, "fetch");
    if (k == K_ILL) begin
`ifdef CTRL_TRAP_EN
      push(rb(), rb(), op, B_IMM, "decode");
      for (int i = 0; i < 5; i++) push(rb(), rb(), ro(), M_TRAP, "trap_illegal");
`else
      push(rb(), rb(), op, B_IMM | M_RET, "decode_illegal");
`endif
    end else begin
      push(rb(), rb(), op, B_IMM, "decode");
    end
    case (k)
      K_R: begin
        push(rb(), rb(), ro(), M_ALUA | A_FUNCT, "exec_r");
        push(rb(), rb(), ro(), M_RWE | M_RDST | M_RET, "wb_alu_r");
      end
      K_I: begin
        push(rb(), rb(), ro(), M_ALUA | B_IMM | A_FUNCT, "exec_i");
        push(rb(), rb(), ro(), M_RWE | M_RET, "wb_alu_i");
      end
      K_LW: begin
        push(rb(), rb(), ro(), M_ALUA | B_IMM | A_LW, "mem_addr_lw");
        for (int i = 0; i < mw; i++) push(1'b0, rb(), ro(), M_MREQ | M_IORD, "mem_rd_wait");
        push(1'b1, rb(), ro(), M_MREQ | M_IORD, "mem_rd");
        push(rb(), rb(), ro(), M_RWE | M_M2R | M_RET, "wb_mem");
      end
      K_SW: begin
        push(rb(), rb(), ro(), M_ALUA | B_IMM | A_SW, "mem_addr_sw");
        for (int i = 0; i < mw; i++) push(1'b0, rb(), ro(), M_MREQ | M_MWE | M_IORD, "mem_wr_wait");
        push(1'b1, rb(), ro(), M_MREQ | M_MWE | M_IORD | M_RET, "mem_wr");
      end
      K_BEQZ, K_BNEZ: begin
        taken = (k == K_BEQZ) ? zv : !zv;
        push(rb(), zv, ro(), A_BEQZ | P_BR | M_RET | (taken ? M_PCWE : 19'd0), "branch");
      end
      K_J: push(rb(), rb(), ro(), P_JMP | M_PCWE | M_RET, "jump");
      K_HALT: for (int i = 0; i < 20; i++) push(rb(), rb(), ro(), M_HALT, "halted");
      default: ;
    endcase
  endtask

  task automatic run_queue();
    step_t s;
    string t;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      t = tq.pop_front();
      mem_ready = s.mr;
      zero      = s.z;
      opcode    = s.op;
      #1 check_eq(t, 32'(out_vec), 32'(s.ev));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_outputs", 32'(out_vec), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ialu[12] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h14,
                             6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1c};
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0:       op = 6'h00;
      1, 2:    op = ialu[$urandom_range(0, 11)];
      3:       op = 6'h23;
      4:       op = 6'h2b;
      5:       op = 6'h04;
      6:       op = 6'h05;
      7:       op = 6'h02;
      default: op = ro();
    endcase
`ifdef CTRL_TRAP_EN
    if (kind_of(op) == K_ILL) op = 6'h00;
`endif
    if (op == 6'h3f) op = 6'h00;
    return op;
  endfunction

  initial begin
    opcode = 6'h00;
    zero   = 1'b0;
    @(negedge clk);
    do_reset();

    add_instr(6'h00, 0, 0, 1'b0);
    add_instr(6'h23, 0, 3, 1'b0);
    add_instr(6'h2b, 1, 2, 1'b0);
    add_instr(6'h04, 0, 0, 1'b1);
    add_instr(6'h04, 0, 0, 1'b0);
    add_instr(6'h05, 0, 0, 1'b1);
    add_instr(6'h05, 0, 0, 1'b0);
    add_instr(6'h08, 2, 0, 1'b0);
    add_instr(6'h02, 0, 0, 1'b0);
    add_instr(6'h3f, 0, 0, 1'b0);
    run_queue();

    do_reset();
    add_instr(6'h3e, 0, 0, 1'b0);
`ifndef CTRL_TRAP_EN
    add_instr(6'h00, 0, 0, 1'b0);
`endif
    run_queue();

    do_reset();
`ifdef CTRL_TRAP_EN
    for (int i = 0; i < WMAX; i++) push(1'b0, rb(), ro(), V_FETCH, "fetch_wait");
    for (int i = 0; i < 5; i++) push(rb(), rb(), ro(), M_TRAP, "trap_timeout");
`else
    add_instr(6'h2b, 10, 9, 1'b0);
`endif
    run_queue();

    do_reset();
    push(1'b0, 1'b0, 6'h00, V_FETCH, "fetch_wait");
    push(1'b0, 1'b0, 6'h00, V_FETCH, "fetch_wait");
    run_queue();
    do_reset();
    add_instr(6'h23, WMAX - 1, WMAX - 1, 1'b0);
    run_queue();

    for (int n = 0; n < 150; n++) begin
      add_instr(pick_op(), $urandom_range(0, MAXW), $urandom_range(0, MAXW), rb());
      run_queue();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
